rx_data_sampler: RTL and testbench

- Upstream neighbour of the RX deserializer. Oversamples the serial line rx_in and takes a 3-point majority vote around each bit centre.
- Delivers one voted bit per bit period on sampled_bit, with a one-cycle strobe on finish. These drive the deserializer's sampled_bit/finish inputs directly.
- Also exports the edge and bit counters so the RX control FSM can sequence start, data, parity and stop.

---
 rtl/rx_data_sampler_if.sv | 33 +++
 rtl/rx_data_sampler.sv | 110 +++++++++++
 tb/tb_rx_data_sampler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_data_sampler_if.sv
// Handshake bundle between the RX FSM/line side and the oversampling bit sampler.
// The master side drives the line and control; the slave side is the sampler itself.
interface rx_data_sampler_if #(
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  dat_samp_en;
    logic                  sampled_bit;
    logic                  finish;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;

    modport master (
        output rx_in,
        output prescale,
        output dat_samp_en,
        input  sampled_bit,
        input  finish,
        input  edge_cnt,
        input  bit_cnt
    );

    modport slave (
        input  rx_in,
        input  prescale,
        input  dat_samp_en,
        output sampled_bit,
        output finish,
        output edge_cnt,
        output bit_cnt
    );
endinterface

// File: rtl/rx_data_sampler.sv
// Oversampling RX bit sampler: synchronizes rx_in, tracks position within each bit
// and majority-votes three samples around the bit centre, strobing finish per bit.
module rx_data_sampler #(
    parameter int PRESCALE_W   = 6,
    parameter int MIN_PRESCALE = 8
) (
    input  logic               clk,
    input  logic               rst,
    rx_data_sampler_if.slave   bus
);

    localparam logic [PRESCALE_W-1:0] MIN_PS = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [PRESCALE_W-1:0] ONE    = PRESCALE_W'(1);

    function automatic logic [PRESCALE_W-1:0] clamp_ps(input logic [PRESCALE_W-1:0] p);
        return (p < MIN_PS) ? MIN_PS : p;
    endfunction

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                  sync_ff1;
    logic                  sync_ff2;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] ps_lat;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] half_m1;
    logic [PRESCALE_W-1:0] half_p1;
    logic [PRESCALE_W-1:0] last;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  s0;
    logic                  s1;
    logic                  sampled_bit;
    logic                  finish;

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
        end else begin
            sync_ff1 <= bus.rx_in;
            sync_ff2 <= sync_ff1;
        end
    end

    assign rx_s = sync_ff2;

    // Ratio is captured between frames only, so a mid-frame change cannot skew a bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_lat <= MIN_PS;
        end else if (!bus.dat_samp_en) begin
            ps_lat <= clamp_ps(bus.prescale);
        end
    end

    assign half    = ps_lat >> 1;
    assign half_m1 = half - ONE;
    assign half_p1 = half + ONE;
    assign last    = ps_lat - ONE;

    // Position within the bit and completed-bit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!bus.dat_samp_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == last) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    // Centre samples and vote; the third sample is taken live from rx_s.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            sampled_bit <= 1'b0;
            finish      <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (bus.dat_samp_en) begin
                if (edge_cnt == half_m1) begin
                    s0 <= rx_s;
                end
                if (edge_cnt == half) begin
                    s1 <= rx_s;
                end
                if (edge_cnt == half_p1) begin
                    sampled_bit <= majority(s0, s1, rx_s);
                    finish      <= 1'b1;
                end
            end
        end
    end

    assign bus.sampled_bit = sampled_bit;
    assign bus.finish      = finish;
    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Bench for rx_data_sampler: table of majority/prescale vectors plus hand-written
// frame sequences; every expected strobe is queued and matched when finish fires.
module tb_rx_data_sampler;

    logic clk;
    logic rst;

    rx_data_sampler_if #(.PRESCALE_W(6)) bus ();

    rx_data_sampler #(
        .PRESCALE_W  (6),
        .MIN_PRESCALE(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       exp_bit;
        int         exp_edge;
        int         exp_bcnt;
    } exp_t;

    typedef struct {
        int          ps;
        logic [63:0] mask;
        logic        base;
        logic        exp_bit;
        int          nbits;
    } vec_t;

    exp_t sb[$];
    exp_t mon_rec;
    vec_t vecs[13];
    int   checks;
    int   errors;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full bit period starting at edge_cnt=0; mask bit i forces rx_s to ~base at position i.
    task automatic run_bit(input int ps_eff, input logic [63:0] mask, input logic base,
                           input logic exp_bit, input int bidx);
        exp_t r;
        r.exp_bit  = exp_bit;
        r.exp_edge = ps_eff / 2 + 2;
        r.exp_bcnt = bidx % 16;
        check("bit_start_edge_cnt", int'(bus.edge_cnt), 0);
        check("bit_start_bit_cnt", int'(bus.bit_cnt), bidx % 16);
        sb.push_back(r);
        for (int k = 0; k < ps_eff; k++) begin
            bus.rx_in = base ^ (((k + 2) < 64) ? mask[k + 2] : 1'b0);
            tick();
        end
    endtask

    task automatic start_frame(input int ps);
        bus.dat_samp_en = 1'b0;
        bus.prescale    = 6'(ps);
        tick();
        check("frame_clear_edge_cnt", int'(bus.edge_cnt), 0);
        check("frame_clear_bit_cnt", int'(bus.bit_cnt), 0);
        bus.dat_samp_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (bus.finish === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish: edge_cnt=%0d bit_cnt=%0d, no strobe expected",
                         bus.edge_cnt, bus.bit_cnt);
            end else begin
                mon_rec = sb.pop_front();
                check("strobe_sampled_bit", int'(bus.sampled_bit), int'(mon_rec.exp_bit));
                check("strobe_edge_cnt", int'(bus.edge_cnt), mon_rec.exp_edge);
                check("strobe_bit_cnt", int'(bus.bit_cnt), mon_rec.exp_bcnt);
            end
        end
    end

    initial begin
        int ps_eff;
        checks = 0;
        errors = 0;

        vecs[0]  = '{ps: 16, mask: 64'h100,         base: 1'b1, exp_bit: 1'b1, nbits: 1};
        vecs[1]  = '{ps: 16, mask: 64'h180,         base: 1'b1, exp_bit: 1'b0, nbits: 1};
        vecs[2]  = '{ps: 16, mask: 64'h200,         base: 1'b1, exp_bit: 1'b1, nbits: 1};
        vecs[3]  = '{ps: 16, mask: 64'h280,         base: 1'b1, exp_bit: 1'b0, nbits: 1};
        vecs[4]  = '{ps: 16, mask: 64'h440,         base: 1'b1, exp_bit: 1'b1, nbits: 1};
        vecs[5]  = '{ps: 16, mask: 64'h380,         base: 1'b1, exp_bit: 1'b0, nbits: 1};
        vecs[6]  = '{ps: 16, mask: 64'h280,         base: 1'b0, exp_bit: 1'b1, nbits: 1};
        vecs[7]  = '{ps: 8,  mask: 64'h30,          base: 1'b1, exp_bit: 1'b0, nbits: 1};
        vecs[8]  = '{ps: 8,  mask: 64'h08,          base: 1'b1, exp_bit: 1'b1, nbits: 1};
        vecs[9]  = '{ps: 9,  mask: 64'h28,          base: 1'b1, exp_bit: 1'b0, nbits: 2};
        vecs[10] = '{ps: 4,  mask: 64'h0,           base: 1'b1, exp_bit: 1'b1, nbits: 2};
        vecs[11] = '{ps: 0,  mask: 64'h0,           base: 1'b0, exp_bit: 1'b0, nbits: 2};
        vecs[12] = '{ps: 63, mask: 64'h1_8000_0000, base: 1'b1, exp_bit: 1'b0, nbits: 1};

        // Reset state
        rst = 1'b1;
        bus.rx_in = 1'b1;
        bus.prescale = 6'd8;
        bus.dat_samp_en = 1'b0;
        tick();
        tick();
        check("reset_sampled_bit", int'(bus.sampled_bit), 0);
        check("reset_finish", int'(bus.finish), 0);
        check("reset_edge_cnt", int'(bus.edge_cnt), 0);
        check("reset_bit_cnt", int'(bus.bit_cnt), 0);
        check("reset_rx_s", int'(dut.rx_s), 1);
        rst = 1'b0;

        // Synchronizer latency with sampling disabled
        tick();
        tick();
        check("sync_idle", int'(dut.rx_s), 1);
        bus.rx_in = 1'b0;
        tick();
        check("sync_n_plus_1", int'(dut.rx_s), 1);
        tick();
        check("sync_n_plus_2", int'(dut.rx_s), 0);

        // Nominal: line low for 20 cycles, then 10 bits at prescale 8
        repeat (18) tick();
        bus.dat_samp_en = 1'b1;
        for (int b = 0; b < 10; b++) run_bit(8, 64'h0, 1'b0, 1'b0, b);
        check("nominal_end_bit_cnt", int'(bus.bit_cnt), 10);
        bus.dat_samp_en = 1'b0;
        tick();
        check("nominal_off_edge_cnt", int'(bus.edge_cnt), 0);
        check("nominal_off_bit_cnt", int'(bus.bit_cnt), 0);

        // Table-driven majority and prescale vectors
        for (int v = 0; v < 13; v++) begin
            ps_eff = (vecs[v].ps < 8) ? 8 : vecs[v].ps;
            start_frame(vecs[v].ps);
            for (int b = 0; b < vecs[v].nbits; b++)
                run_bit(ps_eff, vecs[v].mask, vecs[v].base, vecs[v].exp_bit, b);
        end

        // Prescale change mid-frame is ignored until re-enable
        start_frame(8);
        run_bit(8, 64'h0, 1'b1, 1'b1, 0);
        bus.prescale = 6'd16;
        run_bit(8, 64'h0, 1'b1, 1'b1, 1);
        run_bit(8, 64'h0, 1'b1, 1'b1, 2);
        start_frame(16);
        run_bit(16, 64'h0, 1'b1, 1'b1, 0);
        run_bit(16, 64'h0, 1'b1, 1'b1, 1);

        // Enable abort at edge_cnt=4
        start_frame(8);
        run_bit(8, 64'h0, 1'b0, 1'b0, 0);
        bus.rx_in = 1'b1;
        repeat (4) tick();
        check("abort_pre_edge_cnt", int'(bus.edge_cnt), 4);
        bus.dat_samp_en = 1'b0;
        tick();
        check("abort_edge_cnt", int'(bus.edge_cnt), 0);
        check("abort_bit_cnt", int'(bus.bit_cnt), 0);
        check("abort_sampled_bit", int'(bus.sampled_bit), 0);
        check("abort_finish", int'(bus.finish), 0);
        repeat (6) tick();
        check("abort_sampled_bit_hold", int'(bus.sampled_bit), 0);

        // Synchronous reset mid-bit at edge_cnt=5, bit_cnt=3
        start_frame(8);
        for (int b = 0; b < 3; b++) run_bit(8, 64'h0, 1'b1, 1'b1, b);
        repeat (5) tick();
        check("prereset_edge_cnt", int'(bus.edge_cnt), 5);
        check("prereset_bit_cnt", int'(bus.bit_cnt), 3);
        check("prereset_sampled_bit", int'(bus.sampled_bit), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_sampled_bit", int'(bus.sampled_bit), 0);
        check("midreset_finish", int'(bus.finish), 0);
        check("midreset_edge_cnt", int'(bus.edge_cnt), 0);
        check("midreset_bit_cnt", int'(bus.bit_cnt), 0);
        run_bit(8, 64'h0, 1'b1, 1'b1, 0);
        run_bit(8, 64'h0, 1'b0, 1'b0, 1);

        // bit_cnt wraps 15 -> 0 with an alternating line
        start_frame(8);
        for (int b = 0; b < 17; b++) run_bit(8, 64'h0, 1'(b % 2), 1'(b % 2), b);
        check("wrap_bit_cnt", int'(bus.bit_cnt), 1);

        bus.dat_samp_en = 1'b0;
        repeat (5) tick();
        check("all_strobes_seen", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
